// File: rtl/tc_rn_acc_if.sv
// tc_rn_acc_if: beat/result bundle for the tensor-core row accumulator.
//   in_valid/in_first/in_last/in : input beat (NUM_IN signed DW_DATA elements)
//   out_valid/out/out_sat         : per-lane result strobe, values, sticky flags
//   busy/protocol_err             : accumulation status
// master = beat producer / result consumer, slave = accumulator.
interface tc_rn_acc_if #(
   parameter int TILE_M  = 4,
   parameter int TILE_K  = 8,
   parameter int NUM_IN  = 32,
   parameter int DW_DATA = 8,
   parameter int DW_ACC  = 20
) ();
   logic                       in_valid;
   logic                       in_first;
   logic                       in_last;
   logic [NUM_IN*DW_DATA-1:0]  in;
   logic                       out_valid;
   logic [TILE_M*DW_ACC-1:0]   out;
   logic [TILE_M-1:0]          out_sat;
   logic                       busy;
   logic                       protocol_err;

   modport master (
      output in_valid, in_first, in_last, in,
      input  out_valid, out, out_sat, busy, protocol_err
   );

   modport slave (
      input  in_valid, in_first, in_last, in,
      output out_valid, out, out_sat, busy, protocol_err
   );
endinterface

// File: rtl/tc_rn_acc.sv
// tc_rn_acc: TILE_M parallel adder trees, each reducing TILE_K signed elements
// per beat through clog2(TILE_K) registered levels, followed by a per-lane
// accumulator (saturating or wrapping) and a held output register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tc_rn_acc_if.slave (beats in, results/status out)
// out_valid pulses L+1 cycles after a last beat is sampled.

// Per-lane datapath: sign-extend, heap-ordered adder tree, accumulator, output reg.
module tc_rn_acc_lane #(
   parameter int TILE_K  = 8,
   parameter int DW_DATA = 8,
   parameter int DW_ACC  = 20,
   parameter int SAT     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [TILE_K-1:0][DW_DATA-1:0] elems,
   input  logic                           acc_en,   // tree root holds a valid beat
   input  logic                           acc_ld,   // that beat opens an accumulation
   input  logic                           out_ld,   // accumulator holds a closed result
   output logic [DW_ACC-1:0]              res,
   output logic                           res_sat
);
   localparam int NN = TILE_K - 1;  // internal (registered) tree nodes
   localparam logic [DW_ACC-1:0] AMAX = {1'b0, {(DW_ACC-1){1'b1}}};
   localparam logic [DW_ACC-1:0] AMIN = {1'b1, {(DW_ACC-1){1'b0}}};

   logic [TILE_K-1:0][DW_ACC-1:0] leaf;
   logic [NN-1:0][DW_ACC-1:0]     node;
   // Heap order: index 0 is the root, children of i are 2i+1 and 2i+2,
   // leaves sit above the internal nodes. Complete tree since TILE_K is 2^L,
   // so every root-to-leaf path crosses exactly L registers.
   logic [2*TILE_K-2:0][DW_ACC-1:0] heap;

   logic [DW_ACC-1:0] acc, base, nxt;
   logic [DW_ACC:0]   sum;
   logic              ovf, sticky;

   always_comb begin
      leaf = '0;
      for (int j = 0; j < TILE_K; j++)
         leaf[j] = {{(DW_ACC-DW_DATA){elems[j][DW_DATA-1]}}, elems[j]};
   end

   assign heap = {leaf, node};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) node <= '0;
      else
         for (int i = 0; i < NN; i++)
            node[i] <= heap[2*i+1] + heap[2*i+2];
   end

   // One guard bit catches signed overflow of acc + tree sum.
   always_comb begin
      base = acc_ld ? '0 : acc;
      sum  = {base[DW_ACC-1], base} + {heap[0][DW_ACC-1], heap[0]};
      ovf  = sum[DW_ACC] ^ sum[DW_ACC-1];
      nxt  = sum[DW_ACC-1:0];
      if (SAT != 0 && ovf) nxt = sum[DW_ACC] ? AMIN : AMAX;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         sticky  <= 1'b0;
         res     <= '0;
         res_sat <= 1'b0;
      end else begin
         if (acc_en) begin
            acc    <= nxt;
            // first beat clears the flag before its own overflow is folded in
            sticky <= (sticky & ~acc_ld) | ovf;
         end
         if (out_ld) begin
            res     <= acc;
            res_sat <= sticky;
         end
      end
   end
endmodule

module tc_rn_acc #(
   parameter int TILE_M  = 4,
   parameter int TILE_K  = 8,
   parameter int NUM_IN  = 32,
   parameter int DW_DATA = 8,
   parameter int DW_ACC  = 20,
   parameter int SAT     = 1
) (
   input  logic          clk,
   input  logic          rst,
   tc_rn_acc_if.slave    bus
);
   localparam int L = $clog2(TILE_K);

   if (NUM_IN != TILE_M*TILE_K) begin : g_chk_num
      $error("tc_rn_acc: NUM_IN must equal TILE_M*TILE_K");
   end
   if (TILE_K < 2 || (TILE_K & (TILE_K-1)) != 0) begin : g_chk_k
      $error("tc_rn_acc: TILE_K must be a power of two >= 2");
   end
   if (DW_ACC < DW_DATA + L) begin : g_chk_acc
      $error("tc_rn_acc: DW_ACC too narrow for the tree sum");
   end

   // Beat tags travel alongside the tree; stage s matches tree level s.
   logic [L:1] vld_pipe, fst_pipe, lst_pipe;
   logic       acc_done;   // accumulator now holds a closed result
   logic       eff_first;

   logic [TILE_M-1:0][DW_ACC-1:0] lane_out;
   logic [TILE_M-1:0]             lane_sat;

   // A non-first beat with nothing open is promoted to a first beat.
   assign eff_first = bus.in_first | ~bus.busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe         <= '0;
         fst_pipe         <= '0;
         lst_pipe         <= '0;
         acc_done         <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.busy         <= 1'b0;
         bus.protocol_err <= 1'b0;
      end else begin
         for (int s = L; s > 1; s--) begin
            vld_pipe[s] <= vld_pipe[s-1];
            fst_pipe[s] <= fst_pipe[s-1];
            lst_pipe[s] <= lst_pipe[s-1];
         end
         vld_pipe[1] <= bus.in_valid;
         fst_pipe[1] <= eff_first;
         lst_pipe[1] <= bus.in_last;

         if (bus.in_valid) begin
            if (bus.in_last)    bus.busy <= 1'b0;
            else if (eff_first) bus.busy <= 1'b1;
         end
         // malformed: first while open, or continuation while idle
         bus.protocol_err <= bus.in_valid & (bus.in_first == bus.busy);

         acc_done      <= vld_pipe[L] & lst_pipe[L];
         bus.out_valid <= acc_done;
      end
   end

   for (genvar g = 0; g < TILE_M; g++) begin : g_lane
      tc_rn_acc_lane #(
         .TILE_K  (TILE_K),
         .DW_DATA (DW_DATA),
         .DW_ACC  (DW_ACC),
         .SAT     (SAT)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .elems   (bus.in[g*TILE_K*DW_DATA +: TILE_K*DW_DATA]),
         .acc_en  (vld_pipe[L]),
         .acc_ld  (fst_pipe[L]),
         .out_ld  (acc_done),
         .res     (lane_out[g]),
         .res_sat (lane_sat[g])
      );
   end

   assign bus.out     = lane_out;
   assign bus.out_sat = lane_sat;
endmodule

// File: tb/tb_tc_rn_acc.sv
// tb_tc_rn_acc: directed + random beats against an arithmetic reference model
// that sums lane elements with plain integers and predicts each result's
// strobe cycle from the last beat's sampling edge.
module tb_tc_rn_acc;
   localparam int TILE_M  = 4;
   localparam int TILE_K  = 8;
   localparam int NUM_IN  = 32;
   localparam int DW_DATA = 8;
   localparam int DW_ACC  = 20;
   localparam int SAT     = 1;
   localparam int L       = $clog2(TILE_K);
   localparam int IW      = NUM_IN*DW_DATA;
   localparam int OW      = TILE_M*DW_ACC;
   localparam longint AMOD = longint'(1) <<< DW_ACC;
   localparam longint AMAX = AMOD/2 - 1;
   localparam longint AMIN = -(AMOD/2);

   typedef struct {
      int                due;
      logic [OW-1:0]     o;
      logic [TILE_M-1:0] s;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   tc_rn_acc_if #(.TILE_M(TILE_M), .TILE_K(TILE_K), .NUM_IN(NUM_IN),
                  .DW_DATA(DW_DATA), .DW_ACC(DW_ACC)) bus ();

   tc_rn_acc #(.TILE_M(TILE_M), .TILE_K(TILE_K), .NUM_IN(NUM_IN),
               .DW_DATA(DW_DATA), .DW_ACC(DW_ACC), .SAT(SAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int                total = 0;
   int                bad   = 0;
   int                cyc   = 0;
   longint            m_acc [TILE_M];
   logic [TILE_M-1:0] m_sat;
   logic              m_busy, m_err;
   exp_t              q[$];
   logic [OW-1:0]     held_o;
   logic [TILE_M-1:0] held_s;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] fill(int v);
      logic [DW_DATA-1:0] t;
      logic [IW-1:0]      r;
      t = v[DW_DATA-1:0];
      for (int e = 0; e < NUM_IN; e++) r[e*DW_DATA +: DW_DATA] = t;
      return r;
   endfunction

   function automatic logic [IW-1:0] rnd();
      logic [IW-1:0] r;
      for (int e = 0; e < NUM_IN; e++) r[e*DW_DATA +: DW_DATA] = DW_DATA'($urandom);
      return r;
   endfunction

   function automatic logic [OW-1:0] lanes(longint v);
      logic [OW-1:0] r;
      for (int g = 0; g < TILE_M; g++) r[g*DW_ACC +: DW_ACC] = v[DW_ACC-1:0];
      return r;
   endfunction

   function automatic longint lsum(logic [IW-1:0] d, int g);
      longint s = 0;
      for (int k = 0; k < TILE_K; k++)
         s += longint'($signed(d[(g*TILE_K+k)*DW_DATA +: DW_DATA]));
      return s;
   endfunction

   // Reference behaviour of one sampled beat.
   task automatic model(bit v, bit f, bit l, logic [IW-1:0] d);
      exp_t   e;
      longint a;
      bit     ef;
      if (!v) begin
         m_err = 1'b0;
         return;
      end
      m_err = (f && m_busy) || (!f && !m_busy);
      ef    = f || !m_busy;
      for (int g = 0; g < TILE_M; g++) begin
         if (ef) begin
            a        = lsum(d, g);
            m_sat[g] = 1'b0;
         end else a = m_acc[g] + lsum(d, g);
         if (a > AMAX) begin
            m_sat[g] = 1'b1;
            a = (SAT != 0) ? AMAX : a - AMOD;
         end else if (a < AMIN) begin
            m_sat[g] = 1'b1;
            a = (SAT != 0) ? AMIN : a + AMOD;
         end
         m_acc[g] = a;
      end
      if (l) m_busy = 1'b0;
      else if (ef) m_busy = 1'b1;
      if (l) begin
         e.due = cyc + L + 1;
         for (int g = 0; g < TILE_M; g++) e.o[g*DW_ACC +: DW_ACC] = m_acc[g][DW_ACC-1:0];
         e.s = m_sat;
         q.push_back(e);
      end
   endtask

   task automatic check_cycle();
      exp_t e;
      bit   ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
         e      = q.pop_front();
         held_o = e.o;
         held_s = e.s;
      end
      chk("out", bus.out, held_o);
      chk("out_sat", bus.out_sat, held_s);
      chk("busy", bus.busy, m_busy);
      chk("protocol_err", bus.protocol_err, m_err);
   endtask

   task automatic step(bit v, bit f, bit l, logic [IW-1:0] d);
      bus.in_valid = v;
      bus.in_first = f;
      bus.in_last  = l;
      bus.in       = d;
      @(posedge clk);
      cyc++;
      model(v, f, l, d);
      #1;
      check_cycle();
   endtask

   // bubbles carry random first/last/data that must be ignored
   task automatic bubbles(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), rnd());
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      q.delete();
      m_busy = 1'b0;
      m_err  = 1'b0;
      held_o = '0;
      held_s = '0;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out", bus.out, '0);
      chk("rst_out_sat", bus.out_sat, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_protocol_err", bus.protocol_err, 1'b0);
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [IW-1:0] dv;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      bus.in       = '0;
      m_sat        = '0;
      for (int g = 0; g < TILE_M; g++) m_acc[g] = 0;
      #2;
      do_reset();

      // single-beat result
      step(1'b1, 1'b1, 1'b1, fill(1));
      bubbles(6);
      chk("r035_out", bus.out, lanes(8));
      chk("r035_sat", bus.out_sat, '0);

      // three beats with bubbles in between
      step(1'b1, 1'b1, 1'b0, fill(127));
      bubbles(2);
      step(1'b1, 1'b0, 1'b0, fill(127));
      bubbles(2);
      step(1'b1, 1'b0, 1'b1, fill(127));
      bubbles(6);
      chk("r036_out", bus.out, lanes(3048));

      // long saturating run, then a clean single beat
      step(1'b1, 1'b1, 1'b0, fill(127));
      for (int i = 0; i < 598; i++) step(1'b1, 1'b0, 1'b0, fill(127));
      step(1'b1, 1'b0, 1'b1, fill(127));
      bubbles(6);
      chk("r037_out", bus.out, lanes(524287));
      chk("r037_sat", bus.out_sat, 4'hF);
      step(1'b1, 1'b1, 1'b1, fill(1));
      bubbles(6);
      chk("r037_next_out", bus.out, lanes(8));
      chk("r037_next_sat", bus.out_sat, '0);

      // back-to-back results: last beat then immediate first=last beat
      step(1'b1, 1'b1, 1'b0, fill(0));
      step(1'b1, 1'b0, 1'b1, fill(2));
      step(1'b1, 1'b1, 1'b1, fill(-1));
      bubbles(3);
      chk("r038_first_valid", bus.out_valid, 1'b1);
      chk("r038_first_out", bus.out, lanes(16));
      bubbles(1);
      chk("r038_second_valid", bus.out_valid, 1'b1);
      chk("r038_second_out", bus.out, lanes(-8));
      bubbles(4);

      // reset mid-accumulation, then a continuation beat with nothing open
      step(1'b1, 1'b1, 1'b0, fill(7));
      step(1'b1, 1'b0, 1'b0, fill(7));
      do_reset();
      step(1'b1, 1'b0, 1'b0, fill(3));
      chk("r039_perr", bus.protocol_err, 1'b1);
      step(1'b1, 1'b0, 1'b1, fill(5));
      bubbles(6);
      chk("r039_out", bus.out, lanes(64));

      // first while open restarts the sum
      step(1'b1, 1'b1, 1'b0, fill(10));
      step(1'b1, 1'b1, 1'b0, fill(1));
      chk("restart_perr", bus.protocol_err, 1'b1);
      step(1'b1, 1'b0, 1'b1, fill(2));
      bubbles(6);
      chk("restart_out", bus.out, lanes(24));

      // lane-distinct alternating data sums to zero in every lane
      for (int g = 0; g < TILE_M; g++)
         for (int k = 0; k < TILE_K; k++)
            dv[(g*TILE_K+k)*DW_DATA +: DW_DATA] = (k % 2 == 0) ? DW_DATA'(g+1) : DW_DATA'(-(g+1));
      step(1'b1, 1'b1, 1'b1, dv);
      bubbles(6);
      chk("r040_out", bus.out, '0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0, rnd());
      bubbles(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tc_rn_acc.md
TC_RN_ACC -- requirements
Module: tc_rn_acc

Interface
REQ-001 SHALL have parameter TILE_M, default 4: number of output lanes (adder trees).
REQ-002 SHALL have parameter TILE_K, default 8: inputs reduced per lane per beat; power of two, at least 2.
REQ-003 SHALL have parameter NUM_IN, default 32: input element count; elaboration SHALL fail unless NUM_IN == TILE_M*TILE_K.
REQ-004 SHALL have parameter DW_DATA, default 8: signed input element width.
REQ-005 SHALL have parameter DW_ACC, default 20: signed accumulator and output width; elaboration SHALL fail unless DW_ACC >= DW_DATA+clog2(TILE_K).
REQ-006 SHALL have parameter SAT, default 1: 1 selects saturating accumulation, 0 selects two's-complement wrap.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1 bit: beat present.
REQ-010 SHALL have port in_first, input, 1 bit: beat opens an accumulation.
REQ-011 SHALL have port in_last, input, 1 bit: beat closes an accumulation.
REQ-012 SHALL have port in, input, NUM_IN*DW_DATA bits: signed elements; lane g uses elements g*TILE_K to g*TILE_K+TILE_K-1.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-014 SHALL have port out, output, TILE_M*DW_ACC bits: lane g result at bits g*DW_ACC upward.
REQ-015 SHALL have port out_sat, output, TILE_M bits: per-lane saturation flag, qualified by out_valid.
REQ-016 SHALL have port busy, output, 1 bit: an accumulation is open at the input side.
REQ-017 SHALL have port protocol_err, output, 1 bit: one-cycle pulse on a malformed beat.

Function
REQ-018 SHALL sign-extend each element to DW_ACC bits and sum per lane through a binary tree with L = clog2(TILE_K) registered levels.
REQ-019 SHALL carry in_valid, in_first and in_last through a valid pipeline aligned with the tree levels.
REQ-020 SHALL ignore beats with in_valid=0 (bubbles); bubbles SHALL NOT alter accumulators, busy or flags.
REQ-021 SHALL accept one beat per cycle with no stall path.
REQ-022 SHALL make the accumulator register load the tree sum on a first beat and add the tree sum otherwise.
REQ-023 SHALL, when SAT=1, clamp each lane to the range -2^(DW_ACC-1) to 2^(DW_ACC-1)-1 and set the lane's sticky saturation bit.
REQ-024 SHALL, when SAT=0, wrap the result and set the lane's sticky bit on signed overflow.
REQ-025 SHALL clear the sticky saturation bits on every first beat before that beat's saturation check.
REQ-026 SHALL raise out_valid for exactly one cycle, L+1 cycles after a last beat is sampled (4 cycles at defaults).
REQ-027 SHALL hold out and out_sat at the closed result until the next out_valid.
REQ-028 SHALL produce a single-beat result when in_first and in_last are both 1 on one beat.
REQ-029 SHALL support a first beat in the cycle immediately after a last beat with no bubble, keeping the two results independent.
REQ-030 SHALL set busy on a sampled valid beat with in_first=1 and in_last=0; SHALL clear busy on a sampled valid beat with in_last=1.
REQ-031 SHALL, for a valid beat with in_first=0 while busy=0, pulse protocol_err in the next cycle and treat the beat as a first beat.
REQ-032 SHALL, for a valid beat with in_first=1 while busy=1, pulse protocol_err, discard the open partial sum and restart the accumulation.

Reset
REQ-033 SHALL, while rst=1, immediately clear all pipeline valids, tree registers, accumulators, out, out_sat, out_valid, busy and protocol_err to 0.
REQ-034 SHALL discard any accumulation interrupted by reset and emit no out_valid for it.

Verification
REQ-035 SHALL cover: all inputs 1, first=last=1 -> at cycle +4, out_valid=1, each lane 8, out_sat=0.
REQ-036 SHALL cover: 3 beats of all 127 (first, mid, last) with 2 bubbles in between -> single out_valid, each lane 3048.
REQ-037 SHALL cover: SAT=1, 600 beats of all 127 -> lane 524287, out_sat=1; the next single beat of all 1 -> 8 with out_sat=0.
REQ-038 SHALL cover: last beat (all 2) followed next cycle by first=last beat (all -1) -> consecutive out_valid cycles, lanes 16 then -8.
REQ-039 SHALL cover: rst pulse after 2 of 4 beats, then a beat with first=0 -> protocol_err pulse, no stale result, accumulation restarts from that beat.
REQ-040 SHALL cover: lane-distinct data (lane g elements = g+1, -(g+1) alternating in element positions) -> every lane 0, verifying lane slicing.
